simd_sat_sched: RTL

SIMD_SAT_SCHED -- requirements
Module: simd_sat_sched

---
 rtl/simd_sat_sched_pkg.sv | 17 +
 rtl/simd_sat_sched_if.sv | 32 +++
 rtl/simd_sat_sched_rr_arbiter.sv | 43 ++++
 rtl/simd_sat_sched.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/simd_sat_sched_pkg.sv
// Shared SIMD constants and saturation-limit helpers for simd_sat_sched.
package simd_sat_sched_pkg;

    localparam int SIMD_WIN     = 32;
    localparam int SIMD_WOUT    = 16;
    localparam int SIMD_SHIFT_W = 5;

    // Limits are returned as wout-bit two's-complement patterns, zero-extended to 64 bits.
    function automatic logic [63:0] sat_pos_limit(input int unsigned wout);
        return (64'd1 << (wout - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_neg_limit(input int unsigned wout);
        return 64'd1 << (wout - 1);
    endfunction

endpackage

// File: rtl/simd_sat_sched_if.sv
// Request/result bus of simd_sat_sched; master = environment side, slave = DUT side.
interface simd_sat_sched_if
    import simd_sat_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIN     = SIMD_WIN,
    parameter int WOUT    = SIMD_WOUT,
    parameter int SHIFT_W = SIMD_SHIFT_W
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*WIN-1:0]     req_data;
    logic [NUM_REQ*SHIFT_W-1:0] req_shift;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       out_valid;
    logic [WOUT-1:0]            out_data;
    logic [ID_W-1:0]            out_id;
    logic                       out_sat;
    logic                       out_ready;

    modport master (
        output req_valid, req_data, req_shift, out_ready,
        input  req_ready, out_valid, out_data, out_id, out_sat
    );

    modport slave (
        input  req_valid, req_data, req_shift, out_ready,
        output req_ready, out_valid, out_data, out_id, out_sat
    );

endinterface

// File: rtl/simd_sat_sched_rr_arbiter.sv
// Round-robin arbiter: grants the lowest requester above the last granted index, wrapping.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N-1:0]         req_i,
    input  logic                 adv_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] gnt_idx_o
);
    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        logic found;
        found     = 1'b0;
        gnt_o     = '0;
        gnt_idx_o = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            int unsigned idx;
            idx = (32'(ptr_q) + k) % N;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = PW'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) ptr_d = gnt_idx_o;
    end

    // Pointer starts at N-1 so requester 0 wins first after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) ptr_q <= PW'(N - 1);
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/simd_sat_sched.sv
// Shared round/saturate unit: RR-arbitrated requesters, 2-stage round then saturate pipeline.
// Optional SIMD_SAT_STATS_EN adds stat_clr input and a sticky 16-bit sat_count.
module simd_sat_sched
    import simd_sat_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIN     = SIMD_WIN,
    parameter int WOUT    = SIMD_WOUT,
    parameter int SHIFT_W = SIMD_SHIFT_W
) (
    input  logic        clk,
    input  logic        reset,
`ifdef SIMD_SAT_STATS_EN
    input  logic        stat_clr,
    output logic [15:0] sat_count,
`endif
    simd_sat_sched_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic [NUM_REQ-1:0] req_ready_w;
    logic               s1_accept, s2_accept, take;

    logic               s1_valid_q, s1_valid_d;
    logic signed [WIN:0] s1_data_q, s1_data_d;
    logic [ID_W-1:0]    s1_id_q, s1_id_d;

    logic               s2_valid_q, s2_valid_d;
    logic [WOUT-1:0]    s2_data_q, s2_data_d;
    logic [ID_W-1:0]    s2_id_q, s2_id_d;
    logic               s2_sat_q, s2_sat_d;

    logic [WIN-1:0]     op;
    logic [SHIFT_W-1:0] sh;
    logic signed [WIN:0] ext, rc, sum, rnd;
    logic [WIN-WOUT+1:0] hi;
    logic               in_range;
    logic [WOUT-1:0]    sat_val;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk_i     (clk),
        .rst_i     (reset),
        .req_i     (bus.req_valid),
        .adv_i     (take),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    always_comb begin
        s2_accept   = !s2_valid_q || bus.out_ready;
        s1_accept   = !s1_valid_q || s2_accept;
        req_ready_w = (s1_accept && !reset) ? gnt : '0;
        take        = |req_ready_w;
    end

    assign bus.req_ready = req_ready_w;

    // Round half up: add 2^(s-1) in WIN+1 bits, then arithmetic shift.
    always_comb begin
        op  = bus.req_data[gnt_idx*WIN +: WIN];
        sh  = bus.req_shift[gnt_idx*SHIFT_W +: SHIFT_W];
        ext = {op[WIN-1], op};
        rc  = '0;
        if (sh != '0) rc = (WIN+1)'(1) << (sh - SHIFT_W'(1));
        sum = ext + rc;
        rnd = sum >>> sh;
    end

    always_comb begin
        hi       = s1_data_q[WIN:WOUT-1];
        in_range = (&hi) || !(|hi);
        if (in_range)          sat_val = s1_data_q[WOUT-1:0];
        else if (s1_data_q[WIN]) sat_val = WOUT'(sat_neg_limit(WOUT));
        else                   sat_val = WOUT'(sat_pos_limit(WOUT));
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_id_d    = s1_id_q;
        if (s1_accept) begin
            s1_valid_d = take;
            if (take) begin
                s1_data_d = rnd;
                s1_id_d   = gnt_idx;
            end
        end

        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_id_d    = s2_id_q;
        s2_sat_d   = s2_sat_q;
        if (s2_accept) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = sat_val;
                s2_id_d   = s1_id_q;
                s2_sat_d  = !in_range;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_id_q    <= '0;
            s2_sat_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_id_q    <= s2_id_d;
            s2_sat_q   <= s2_sat_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.out_data  = s2_data_q;
    assign bus.out_id    = s2_id_q;
    assign bus.out_sat   = s2_sat_q;

`ifdef SIMD_SAT_STATS_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;

    // Clear has priority over a coinciding increment; the count sticks at all-ones.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (stat_clr)
            sat_cnt_d = '0;
        else if (s2_valid_q && bus.out_ready && s2_sat_q && (sat_cnt_q != '1))
            sat_cnt_d = sat_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) sat_cnt_q <= '0;
        else       sat_cnt_q <= sat_cnt_d;
    end

    assign sat_count = sat_cnt_q;
`endif

endmodule
